// File: rtl/ov7670_capture_if.sv
// Capture-side bundle: OV7670 byte stream in, frame buffer write port and status flags out.
// The capture block masters the frame buffer writes; the environment drives the camera side.
interface ov7670_capture_if #(
    parameter int ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        din;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
    logic              frame_done;
    logic              line_err;
    logic              frame_err;

    modport master (
        input  vsync, href, din,
        output we, addr, dout, frame_done, line_err, frame_err
    );

    modport slave (
        output vsync, href, din,
        input  we, addr, dout, frame_done, line_err, frame_err
    );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: registers the camera byte stream, pairs bytes into RGB565 pixels and
// writes them to a linear frame buffer, discarding settling frames and flagging bad geometry.
module ov7670_capture #(
    parameter int H_PIXELS    = 320,
    parameter int V_LINES     = 240,
    parameter int SKIP_FRAMES = 2,
    parameter int ADDR_W      = 17
) (
    input  logic             pclk,
    input  logic             rst,
    ov7670_capture_if.master cam
);

    localparam int LAST_ADDR  = H_PIXELS * V_LINES - 1;
    localparam int LINE_BYTES = 2 * H_PIXELS;
    localparam int BYTE_W     = $clog2(LINE_BYTES + 2);
    localparam int LINE_W     = $clog2(V_LINES + 3);
    localparam int SKIP_W     = $clog2(SKIP_FRAMES + 1) + 1;

    typedef enum logic [1:0] {WAIT_VS, BLANK, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              vs_s1_q, vs_s1_d, href_s1_q, href_s1_d;
    logic              vs_prev_q, vs_prev_d, href_prev_q, href_prev_d;
    logic [7:0]        din_s1_q, din_s1_d, hi_q, hi_d;
    logic              phase_q, phase_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d, line_total;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              full_q, full_d, adv_q, adv_d, we_q, we_d;
    logic [15:0]       dout_q, dout_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic              skipping, vs_rise, vs_fall, href_rise, href_fall, bad_line, line_open;

    assign skipping  = (skip_q != '0);
    assign vs_rise   = vs_s1_q & ~vs_prev_q;
    assign vs_fall   = ~vs_s1_q & vs_prev_q;
    assign href_rise = href_s1_q & ~href_prev_q;
    assign href_fall = ~href_s1_q & href_prev_q;
    assign bad_line  = (byte_cnt_q != BYTE_W'(LINE_BYTES));
    // A line still open when vsync rises is a truncated line and still counts.
    assign line_open = href_fall | href_s1_q;

    always_comb begin
        vs_s1_d      = cam.vsync;
        href_s1_d    = cam.href;
        din_s1_d     = cam.din;
        vs_prev_d    = vs_s1_q;
        href_prev_d  = href_s1_q;
        state_d      = state_q;
        hi_d         = hi_q;
        phase_d      = 1'b0;
        byte_cnt_d   = byte_cnt_q;
        line_cnt_d   = line_cnt_q;
        skip_d       = skip_q;
        addr_d       = addr_q;
        full_d       = full_q;
        adv_d        = 1'b0;
        we_d         = 1'b0;
        dout_d       = dout_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
        line_total   = line_cnt_q + {{(LINE_W-1){1'b0}}, line_open};

        // Address advances the cycle after each write; it parks on the last slot once full.
        if (adv_q) begin
            if (addr_q == ADDR_W'(LAST_ADDR)) full_d = 1'b1;
            else                              addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            WAIT_VS: begin
                if (vs_s1_q) state_d = BLANK;
            end
            BLANK: begin
                if (vs_fall) begin
                    state_d     = ACTIVE;
                    addr_d      = '0;
                    full_d      = 1'b0;
                    line_cnt_d  = '0;
                    byte_cnt_d  = '0;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = BLANK;
                    if (skipping) begin
                        skip_d = skip_q - SKIP_W'(1);
                    end else begin
                        frame_done_d = 1'b1;
                        if (line_total != LINE_W'(V_LINES)) frame_err_d = 1'b1;
                        if (line_open && bad_line)          line_err_d  = 1'b1;
                    end
                end else begin
                    if (href_fall) begin
                        if (line_cnt_q <= LINE_W'(V_LINES)) line_cnt_d = line_cnt_q + LINE_W'(1);
                        if (bad_line && !skipping)          line_err_d = 1'b1;
                    end
                    if (href_s1_q) begin
                        if (href_rise)                                    byte_cnt_d = BYTE_W'(1);
                        else if (byte_cnt_q != BYTE_W'(LINE_BYTES + 1)) byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            hi_d = din_s1_q;
                        end else if (full_q) begin
                            if (!skipping) frame_err_d = 1'b1;
                        end else begin
                            adv_d  = 1'b1;
                            we_d   = ~skipping;
                            dout_d = {hi_q, din_s1_q};
                        end
                    end
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= WAIT_VS;
            vs_s1_q      <= 1'b0;
            href_s1_q    <= 1'b0;
            din_s1_q     <= '0;
            vs_prev_q    <= 1'b0;
            href_prev_q  <= 1'b0;
            hi_q         <= '0;
            phase_q      <= 1'b0;
            byte_cnt_q   <= '0;
            line_cnt_q   <= '0;
            skip_q       <= SKIP_W'(SKIP_FRAMES);
            addr_q       <= '0;
            full_q       <= 1'b0;
            adv_q        <= 1'b0;
            we_q         <= 1'b0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_s1_q      <= vs_s1_d;
            href_s1_q    <= href_s1_d;
            din_s1_q     <= din_s1_d;
            vs_prev_q    <= vs_prev_d;
            href_prev_q  <= href_prev_d;
            hi_q         <= hi_d;
            phase_q      <= phase_d;
            byte_cnt_q   <= byte_cnt_d;
            line_cnt_q   <= line_cnt_d;
            skip_q       <= skip_d;
            addr_q       <= addr_d;
            full_q       <= full_d;
            adv_q        <= adv_d;
            we_q         <= we_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign cam.we         = we_q;
    assign cam.addr       = addr_q;
    assign cam.dout       = dout_q;
    assign cam.frame_done = frame_done_q;
    assign cam.line_err   = line_err_q;
    assign cam.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 4x3 frame with two settling frames skipped.
module tb_ov7670_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int SK = 2;
    localparam int AW = 17;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    ov7670_capture_if #(.ADDR_W(AW)) bus ();

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SK), .ADDR_W(AW)) dut (
        .pclk (pclk),
        .rst  (rst),
        .cam  (bus)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          b2b_cnt = 0;
    logic        prev_we = 1'b0;
    logic        fd_line_err = 1'b0;
    logic        fd_frame_err = 1'b0;
    logic [AW-1:0] wr_addr [0:255];
    logic [15:0]   wr_data [0:255];
    int          line_len [0:7];

    // Write/frame_done log sampled on the falling edge, away from DUT updates.
    always @(negedge pclk) begin
        if (bus.we === 1'b1) begin
            if (wr_cnt < 256) begin
                wr_addr[wr_cnt] = bus.addr;
                wr_data[wr_cnt] = bus.dout;
            end
            wr_cnt++;
            if (prev_we) b2b_cnt++;
        end
        prev_we = (bus.we === 1'b1);
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_line_err  = bus.line_err;
            fd_frame_err = bus.frame_err;
        end
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(negedge pclk);
        bus.vsync = v;
        bus.href  = h;
        bus.din   = d;
    endtask

    task automatic idle(input logic v, input int n);
        for (int i = 0; i < n; i++) drive(v, 1'b0, 8'h00);
    endtask

    // Frame with per-line byte counts from line_len; trunc raises vsync while href is still high.
    task automatic send_frame(input int n_lines, input bit trunc);
        int b;
        b = 0;
        idle(1'b1, 3);
        idle(1'b0, 2);
        for (int l = 0; l < n_lines; l++) begin
            for (int k = 0; k < line_len[l]; k++) begin
                drive(1'b0, 1'b1, 8'(b));
                b++;
            end
            if (!(trunc && l == n_lines - 1)) idle(1'b0, 2);
        end
        if (trunc) drive(1'b1, 1'b1, 8'hEE);
        idle(1'b1, 4);
    endtask

    task automatic set_lines(input int a, input int b, input int c, input int d);
        line_len[0] = a; line_len[1] = b; line_len[2] = c; line_len[3] = d;
    endtask

    task automatic test_reset();
        bus.vsync = 1'b0; bus.href = 1'b0; bus.din = 8'h00;
        rst = 1'b1;
        idle(1'b0, 3);
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b expected 0", bus.we); end
        n_checks++; if (bus.addr !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.addr); end
        n_checks++; if (bus.dout !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_dout: got %0h expected 0", bus.dout); end
        n_checks++; if ({bus.frame_done, bus.line_err, bus.frame_err} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.frame_done, bus.line_err, bus.frame_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_skip();
        int bw, bf;
        logic [15:0] exp_d;
        set_lines(8, 8, 8, 8);
        bw = wr_cnt; bf = fd_cnt;
        send_frame(3, 1'b0);
        send_frame(3, 1'b0);
        n_checks++; if (wr_cnt - bw !== 0) begin n_fail++; $display("[TB] FAIL skip_no_we: got %0d writes expected 0", wr_cnt - bw); end
        n_checks++; if (fd_cnt - bf !== 0) begin n_fail++; $display("[TB] FAIL skip_no_done: got %0d expected 0", fd_cnt - bf); end
        bw = wr_cnt; bf = fd_cnt;
        send_frame(3, 1'b0);
        n_checks++; if (wr_cnt - bw !== 12) begin n_fail++; $display("[TB] FAIL skip_f3_writes: got %0d expected 12", wr_cnt - bw); end
        n_checks++; if (fd_cnt - bf !== 1) begin n_fail++; $display("[TB] FAIL skip_f3_done: got %0d expected 1", fd_cnt - bf); end
        n_checks++; if (fd_line_err !== 1'b0) begin n_fail++; $display("[TB] FAIL skip_f3_line_err: got %b expected 0", fd_line_err); end
        n_checks++; if (fd_frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL skip_f3_frame_err: got %b expected 0", fd_frame_err); end
        for (int i = 0; i < 12; i++) begin
            exp_d = {8'(2 * i), 8'(2 * i + 1)};
            n_checks++; if (wr_addr[bw + i] !== AW'(i)) begin n_fail++; $display("[TB] FAIL skip_addr[%0d]: got %0d expected %0d", i, wr_addr[bw + i], i); end
            n_checks++; if (wr_data[bw + i] !== exp_d) begin n_fail++; $display("[TB] FAIL skip_data[%0d]: got %h expected %h", i, wr_data[bw + i], exp_d); end
        end
    endtask

    task automatic test_latency();
        idle(1'b1, 2);
        idle(1'b0, 2);
        drive(1'b0, 1'b1, 8'hF8);
        drive(1'b0, 1'b1, 8'h1F);
        drive(1'b0, 1'b0, 8'h00);
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_early_we: got %b expected 0", bus.we); end
        drive(1'b0, 1'b0, 8'h00);
        n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_we: got %b expected 1", bus.we); end
        n_checks++; if (bus.dout !== 16'hF81F) begin n_fail++; $display("[TB] FAIL lat_dout: got %h expected f81f", bus.dout); end
        n_checks++; if (bus.addr !== '0) begin n_fail++; $display("[TB] FAIL lat_addr: got %0d expected 0", bus.addr); end
        drive(1'b0, 1'b0, 8'h00);
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_we_drop: got %b expected 0", bus.we); end
        idle(1'b1, 4);
    endtask

    task automatic test_short_line();
        int bw, bf;
        set_lines(8, 6, 8, 8);
        bw = wr_cnt; bf = fd_cnt;
        send_frame(3, 1'b0);
        n_checks++; if (wr_cnt - bw !== 11) begin n_fail++; $display("[TB] FAIL short_writes: got %0d expected 11", wr_cnt - bw); end
        n_checks++; if (fd_cnt - bf !== 1) begin n_fail++; $display("[TB] FAIL short_done: got %0d expected 1", fd_cnt - bf); end
        n_checks++; if (fd_line_err !== 1'b1) begin n_fail++; $display("[TB] FAIL short_line_err: got %b expected 1", fd_line_err); end
        n_checks++; if (fd_frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL short_frame_err: got %b expected 0", fd_frame_err); end
        n_checks++; if (wr_data[bw + 6] !== 16'h0C0D || wr_addr[bw + 6] !== AW'(6)) begin
            n_fail++; $display("[TB] FAIL short_w6: got %h@%0d expected 0c0d@6", wr_data[bw + 6], wr_addr[bw + 6]);
        end
        n_checks++; if (wr_data[bw + 7] !== 16'h0E0F || wr_addr[bw + 7] !== AW'(7)) begin
            n_fail++; $display("[TB] FAIL short_w7: got %h@%0d expected 0e0f@7", wr_data[bw + 7], wr_addr[bw + 7]);
        end
        n_checks++; if (bus.line_err !== 1'b1) begin n_fail++; $display("[TB] FAIL short_hold: got %b expected 1", bus.line_err); end
        set_lines(8, 8, 8, 8);
        send_frame(3, 1'b0);
        n_checks++; if (fd_line_err !== 1'b0) begin n_fail++; $display("[TB] FAIL short_clear: got %b expected 0", fd_line_err); end
    endtask

    task automatic test_overflow();
        int bw;
        set_lines(8, 8, 8, 8);
        bw = wr_cnt;
        send_frame(4, 1'b0);
        n_checks++; if (wr_cnt - bw !== 12) begin n_fail++; $display("[TB] FAIL ovf_writes: got %0d expected 12", wr_cnt - bw); end
        n_checks++; if (wr_addr[bw + 11] !== AW'(11) || wr_data[bw + 11] !== 16'h1617) begin
            n_fail++; $display("[TB] FAIL ovf_last: got %h@%0d expected 1617@11", wr_data[bw + 11], wr_addr[bw + 11]);
        end
        n_checks++; if (fd_frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_frame_err: got %b expected 1", fd_frame_err); end
        n_checks++; if (fd_line_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_line_err: got %b expected 0", fd_line_err); end
        n_checks++; if (bus.addr !== AW'(11)) begin n_fail++; $display("[TB] FAIL ovf_addr_hold: got %0d expected 11", bus.addr); end
    endtask

    task automatic test_truncation();
        int bw, bf;
        set_lines(8, 4, 8, 8);
        bw = wr_cnt; bf = fd_cnt;
        send_frame(2, 1'b1);
        n_checks++; if (wr_cnt - bw !== 6) begin n_fail++; $display("[TB] FAIL trunc_writes: got %0d expected 6", wr_cnt - bw); end
        n_checks++; if (fd_cnt - bf !== 1) begin n_fail++; $display("[TB] FAIL trunc_done: got %0d expected 1", fd_cnt - bf); end
        n_checks++; if (fd_frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL trunc_frame_err: got %b expected 1", fd_frame_err); end
        n_checks++; if (wr_data[bw + 5] !== 16'h0A0B || wr_addr[bw + 5] !== AW'(5)) begin
            n_fail++; $display("[TB] FAIL trunc_last: got %h@%0d expected 0a0b@5", wr_data[bw + 5], wr_addr[bw + 5]);
        end
    endtask

    task automatic test_odd_byte();
        int bw;
        set_lines(9, 8, 8, 8);
        bw = wr_cnt;
        send_frame(3, 1'b0);
        n_checks++; if (wr_cnt - bw !== 12) begin n_fail++; $display("[TB] FAIL odd_writes: got %0d expected 12", wr_cnt - bw); end
        n_checks++; if (fd_line_err !== 1'b1) begin n_fail++; $display("[TB] FAIL odd_line_err: got %b expected 1", fd_line_err); end
        n_checks++; if (fd_frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL odd_frame_err: got %b expected 0", fd_frame_err); end
        n_checks++; if (wr_data[bw + 3] !== 16'h0607) begin n_fail++; $display("[TB] FAIL odd_w3: got %h expected 0607", wr_data[bw + 3]); end
        n_checks++; if (wr_data[bw + 4] !== 16'h090A) begin n_fail++; $display("[TB] FAIL odd_w4: got %h expected 090a", wr_data[bw + 4]); end
    endtask

    task automatic test_mid_reset();
        int bw, bf;
        bw = wr_cnt; bf = fd_cnt;
        idle(1'b1, 3);
        idle(1'b0, 2);
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        drive(1'b0, 1'b1, 8'h33);
        drive(1'b0, 1'b1, 8'h44);
        drive(1'b0, 1'b1, 8'hAA);
        drive(1'b0, 1'b1, 8'hBB);
        rst = 1'b1;
        n_checks++; if (bus.we !== 1'b1 || bus.addr !== AW'(1) || bus.dout !== 16'h3344) begin
            n_fail++; $display("[TB] FAIL rst_pre: got we=%b %h@%0d expected we=1 3344@1", bus.we, bus.dout, bus.addr);
        end
        drive(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        n_checks++; if ({bus.we, bus.frame_done, bus.line_err, bus.frame_err} !== 4'b0000 || bus.addr !== '0 || bus.dout !== 16'h0) begin
            n_fail++; $display("[TB] FAIL rst_outputs: got we=%b %h@%0d expected we=0 0000@0", bus.we, bus.dout, bus.addr);
        end
        idle(1'b0, 4);
        n_checks++; if (wr_cnt - bw !== 2) begin n_fail++; $display("[TB] FAIL rst_no_we: got %0d writes expected 2", wr_cnt - bw); end
        set_lines(8, 8, 8, 8);
        send_frame(3, 1'b0);
        n_checks++; if (wr_cnt - bw !== 2 || fd_cnt - bf !== 0) begin
            n_fail++; $display("[TB] FAIL rst_skip_restart: got %0d writes %0d done expected 2 writes 0 done", wr_cnt - bw, fd_cnt - bf);
        end
    endtask

    task automatic test_back_to_back();
        n_checks++; if (b2b_cnt !== 0) begin n_fail++; $display("[TB] FAIL we_back_to_back: got %0d expected 0", b2b_cnt); end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_latency();
        test_short_line();
        test_overflow();
        test_truncation();
        test_odd_byte();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
Camera-side frame buffer writer, the counterpart of the VGA read path: the VGA controller fetches 320x240 pixels from the frame buffer, and this block fills it. It samples the OV7670 byte stream (VSYNC/HREF/D[7:0]), assembles RGB565 pixels from byte pairs, and issues single-cycle write strobes with a linear address 0..76799. It also discards settling frames after reset and flags malformed lines and frames.

Parameters:
H_PIXELS, 320, pixels per line (two bytes each)
V_LINES, 240, lines per frame
SKIP_FRAMES, 2, complete frames discarded after reset before the first write
ADDR_W, 17, write address width

Ports:
pclk  in  1  camera pixel clock; sole clock
rst  in  1  synchronous active-high reset
vsync  in  1  camera VSYNC, high = vertical blanking
href  in  1  camera HREF, high = valid bytes on din
din  in  8  camera data byte
we  out  1  frame buffer write strobe, one cycle per pixel
addr  out  ADDR_W  write address
dout  out  16  RGB565 pixel {first byte, second byte}
frame_done  out  1  one-cycle pulse at end of each captured frame
line_err  out  1  sticky per frame: some line byte count != 2*H_PIXELS
frame_err  out  1  sticky per frame: line count != V_LINES, or write beyond the last address attempted

Behaviour:
- Single clock (pclk); reset is synchronous, active-high. On reset: we=0, addr=0, dout=0, frame_done=0, line_err=0, frame_err=0, skip counter=SKIP_FRAMES, state=WAIT_VS.
- vsync, href and din are registered once on entry (stage S1). All latencies below count from the edge that samples a value into S1.
- States:
  - WAIT_VS: wait for S1 vsync=1, then go to BLANK.
  - BLANK: on the S1 vsync 1->0 edge, clear addr, the line counter, byte phase, line_err and frame_err, then go to ACTIVE. If the skip counter is nonzero, ACTIVE runs with writes suppressed (we held 0); all counting still happens, but frame_done and the error flags are not updated.
  - ACTIVE: capture bytes. On the S1 vsync 0->1 edge:
    - Evaluate the line count: frame_err set if line count != V_LINES.
    - If not skipping, pulse frame_done for 1 cycle; the frame_err update is visible in the same cycle.
    - If skipping, decrement the skip counter.
    - Go to BLANK.
- Byte assembly, while S1 href=1:
  - Phase 0: latch the byte as the high byte.
  - Phase 1: dout <= {hi, byte}; we=1 in the next cycle. Latency is 1 cycle after the second byte reaches S1.
  - Phase toggles on every href=1 cycle and is forced to 0 whenever href=0.
- Address:
  - addr presents the address of the current write while we=1, then increments by 1 after each write.
  - First write of a frame uses addr=0.
  - Once H_PIXELS*V_LINES writes are done, further pixels are dropped (we=0, addr holds at H_PIXELS*V_LINES-1) and frame_err is set.
- Lines:
  - A byte counter per line resets on the href rising edge.
  - On the href 1->0 edge: the line counter increments; line_err is set if the byte count != 2*H_PIXELS.
  - An odd trailing byte is dropped.
- vsync rising while href=1 (truncated frame): the partial line is counted, end-of-frame processing runs normally, and no extra write is issued.
- Mid-operation reset: any in-flight pixel is discarded (no we) and the skip count restarts.
- we is never high in two consecutive cycles (at least 2 byte cycles per pixel).
- Error flags hold their value until the next BLANK->ACTIVE transition.

Test Plan:
- Skip: SKIP_FRAMES=2, H_PIXELS=4, V_LINES=3; send 3 frames with byte values incrementing from 0x00 -> frames 1-2: we never high, frame_done never pulses. Frame 3: 12 writes, addr 0..11, first dout=0x0001, frame_done pulses once, line_err=0, frame_err=0.
- Latency: SKIP_FRAMES=0; href rises and bytes 0xF8, 0x1F are applied on consecutive cycles -> we=1 exactly 1 cycle after 0x1F is in S1, with dout=0xF81F and addr=0.
- Short line: in a 4x3 frame, line 2 carries 6 bytes -> 3 writes on that line, line_err=1 at frame_done, and line_err clears at the next frame start.
- Overflow: frame with 4 lines of 4 pixels (V_LINES=3) -> 12 writes, last addr=11, 4 extra pixels dropped (we=0), frame_err=1.
- Truncation/reset: vsync rises after 1.5 lines -> frame_done with frame_err=1 and 6 writes. Separately, assert rst between the two bytes of a pixel -> no we; outputs at reset values the next cycle.
- Odd byte: line of 9 bytes -> 4 writes, 9th byte dropped, line_err=1.
